// File: rtl/serial_boot_loader_pkg.sv
// Shared constants and state encodings for the serial boot loader and its UART receiver.
package serial_boot_loader_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CSUM
    } boot_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/serial_boot_loader_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, glitch rejection on the start bit, framing-error pulse.
module uart_rx_core
    import serial_boot_loader_pkg::*;
#(
    parameter int clk_freq = 35000000,
    parameter int baud     = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_sync,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int DIV  = clk_freq / baud;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    rx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        rx_prev_q;
    logic        valid_q;
    logic        frame_err_q;
    logic        tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
        end else begin
            // NOTE: every clocked register uses <= so all flops see pre-edge values, independent of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: assign defaults before the case so no path leaves a variable unassigned, which would infer a latch.
        tick    = 1'b0;
        state_d = state_q;
        unique case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync) state_d = RX_START;
            end
            RX_START: begin
                tick = (cnt_q == HALF_LAST);
                if (tick) state_d = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                tick = (cnt_q == DIV_LAST);
                if (tick && bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: begin
                tick = (cnt_q == DIV_LAST);
                if (tick) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_prev_q   <= 1'b1;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_prev_q   <= rx_sync;
            cnt_q       <= (state_q == RX_IDLE || tick) ? '0 : cnt_q + CW'(1);
            valid_q     <= (state_q == RX_STOP) && tick && rx_sync;
            frame_err_q <= (state_q == RX_STOP) && tick && !rx_sync;
            if (state_q == RX_START) bit_q <= '0;
            if (state_q == RX_DATA && tick) begin
                shift_q <= {rx_sync, shift_q[7:1]};
                bit_q   <= bit_q + 3'd1;
            end
        end
    end

    always_comb begin
        data      = shift_q;
        valid     = valid_q;
        frame_err = frame_err_q;
    end

endmodule

// File: rtl/serial_boot_loader.sv
// Framed UART image loader: holds the CPU in reset, writes the payload to RAM, releases on 'G'.
module serial_boot_loader
    import serial_boot_loader_pkg::*;
#(
    parameter int clk_freq       = 35000000,
    parameter int baud           = 115200,
    parameter int timeout_cycles = 3500000,
    parameter bit auto_run       = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic        cpu_reset_n,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        error
);

    localparam int TW = $clog2(timeout_cycles + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(timeout_cycles - 1);

    logic        rx_meta_q, rx_sync_q;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_frame_err;

    boot_state_e state_q, state_d;
    logic [15:0] addr_q, len_q;
    logic [7:0]  sum_q;
    logic [TW-1:0] tmo_q;
    logic        cpu_reset_n_q, error_q;
    logic        mem_we_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        timeout, abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    uart_rx_core #(
        .clk_freq (clk_freq),
        .baud     (baud)
    ) u_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_sync   (rx_sync_q),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err)
    );

    // A byte arriving on the last idle cycle reloads the counter instead of aborting.
    assign timeout = (state_q != ST_IDLE) && !rx_valid && (tmo_q == TMO_LAST);
    assign abort   = (state_q != ST_IDLE) && (timeout || rx_frame_err);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (rx_valid) begin
            unique case (state_q)
                ST_IDLE:   if (rx_data == CMD_LOAD) state_d = ST_ADDR_H;
                ST_ADDR_H: state_d = ST_ADDR_L;
                ST_ADDR_L: state_d = ST_LEN_H;
                ST_LEN_H:  state_d = ST_LEN_L;
                ST_LEN_L:  state_d = ({len_q[15:8], rx_data} == 16'h0000) ? ST_CSUM : ST_DATA;
                ST_DATA:   if (len_q == 16'h0001) state_d = ST_CSUM;
                ST_CSUM:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= '0;
            len_q         <= '0;
            sum_q         <= '0;
            tmo_q         <= '0;
            cpu_reset_n_q <= auto_run;
            error_q       <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            mem_we_q <= 1'b0;
            tmo_q    <= (state_q == ST_IDLE || rx_valid) ? '0 : tmo_q + TW'(1);
            if (abort) begin
                error_q <= 1'b1;
            end else if (rx_valid) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rx_data == CMD_LOAD) begin
                            cpu_reset_n_q <= 1'b0;
                            error_q       <= 1'b0;
                            sum_q         <= '0;
                        end else if (rx_data == CMD_GO) begin
                            cpu_reset_n_q <= 1'b1;
                        end
                    end
                    ST_ADDR_H: addr_q[15:8] <= rx_data;
                    ST_ADDR_L: addr_q[7:0]  <= rx_data;
                    ST_LEN_H:  len_q[15:8]  <= rx_data;
                    ST_LEN_L:  len_q[7:0]   <= rx_data;
                    ST_DATA: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= rx_data;
                        addr_q      <= addr_q + 16'd1;
                        len_q       <= len_q - 16'd1;
                        sum_q       <= sum_q + rx_data;
                    end
                    ST_CSUM: if (rx_data != sum_q) error_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        cpu_reset_n = cpu_reset_n_q;
        error       = error_q;
        mem_we      = mem_we_q;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
    end

endmodule

// File: tb/tb_serial_boot_loader.sv
// Scoreboard bench: stimulus pushes expected RAM writes, a monitor pops them on every mem_we.
module tb_serial_boot_loader;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int TMO      = 1000;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        cpu_reset_n, mem_we, busy, error;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q[$];
    wr_t exp_w;

    serial_boot_loader #(
        .clk_freq       (CLK_FREQ),
        .baud           (BAUD),
        .timeout_cycles (TMO),
        .auto_run       (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .cpu_reset_n (cpu_reset_n),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(posedge clk);
        rx = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(posedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(posedge clk);
        rx = 1'b1;
    endtask

    task automatic settle();
        repeat (2 * DIV) @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest queued write; strays count as failures.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %04h data %02h, required no write", mem_addr, mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (mem_addr !== exp_w.addr || mem_wdata !== exp_w.data) begin
                    fails++;
                    $display("FAIL write: got %04h=%02h, required %04h=%02h",
                             mem_addr, mem_wdata, exp_w.addr, exp_w.data);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_cpu_reset_n", 32'(cpu_reset_n), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_error", 32'(error), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        repeat (500) @(posedge clk);
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Basic load of three bytes at 0x0200, checksum A9+01+8D = 0x37
        send_byte(8'h4C);
        @(negedge clk);
        check("f1_busy_mid", 32'(busy), 1);
        check("f1_cpu_held", 32'(cpu_reset_n), 0);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        expect_write(16'h0200, 8'hA9); send_byte(8'hA9);
        expect_write(16'h0201, 8'h01); send_byte(8'h01);
        expect_write(16'h0202, 8'h8D); send_byte(8'h8D);
        send_byte(8'h37);
        settle();
        check("f1_error", 32'(error), 0);
        check("f1_busy", 32'(busy), 0);
        check("f1_cpu_reset_n", 32'(cpu_reset_n), 0);
        check("f1_all_written", 32'(exp_q.size()), 0);
        send_byte(8'h47);
        settle();
        check("go_release", 32'(cpu_reset_n), 1);

        // Address wrap 0xFFFF -> 0x0000, checksum 11+22 = 0x33
        send_byte(8'h4C); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h02);
        expect_write(16'hFFFF, 8'h11); send_byte(8'h11);
        expect_write(16'h0000, 8'h22); send_byte(8'h22);
        send_byte(8'h33);
        settle();
        check("wrap_error", 32'(error), 0);
        check("wrap_busy", 32'(busy), 0);

        // Bad checksum: write stays, error latches
        send_byte(8'h4C); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        expect_write(16'h0300, 8'h55); send_byte(8'h55);
        send_byte(8'h00);
        settle();
        check("csum_error", 32'(error), 1);
        check("csum_busy", 32'(busy), 0);

        // Next 'L' clears error; then the frame stalls until timeout
        send_byte(8'h4C);
        @(negedge clk);
        check("l_clears_error", 32'(error), 0);
        send_byte(8'h00); send_byte(8'h10);
        @(negedge clk);
        check("tmo_busy_before", 32'(busy), 1);
        repeat (TMO + 10) @(posedge clk);
        @(negedge clk);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_error", 32'(error), 1);
        check("tmo_cpu_held", 32'(cpu_reset_n), 0);
        send_byte(8'h47);
        settle();
        check("tmo_go_release", 32'(cpu_reset_n), 1);

        // Framing error on len_lo aborts with no writes
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h05, 1'b0);
        settle();
        check("ferr_busy", 32'(busy), 0);
        check("ferr_error", 32'(error), 1);
        check("ferr_cpu_held", 32'(cpu_reset_n), 0);

        // Zero-length frame goes straight to checksum
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00);
        settle();
        check("len0_error", 32'(error), 0);
        check("len0_busy", 32'(busy), 0);

        // Reset in the middle of the second data byte of a three-byte frame
        send_byte(8'h4C); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        expect_write(16'h0400, 8'h11); send_byte(8'h11);
        @(posedge clk);
        rx = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 1) ? 1'b1 : 1'b0;
            repeat (DIV) @(posedge clk);
        end
        @(negedge clk);
        check("rst_mid_busy_before", 32'(busy), 1);
        check("rst_mid_addr_before", 32'(mem_addr), 32'h0400);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_mem_we", 32'(mem_we), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_error", 32'(error), 0);
        check("rst_mid_cpu_reset_n", 32'(cpu_reset_n), 1);
        check("rst_mid_mem_addr", 32'(mem_addr), 0);
        check("rst_mid_mem_wdata", 32'(mem_wdata), 0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        reset_n = 1'b1;
        repeat (20 * DIV) @(posedge clk);
        @(negedge clk);
        check("rst_mid_idle_after", 32'(busy), 0);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
